// File: rtl/seg7_scan_driver.sv
// Scans a latched 32-bit value as 8 hex digits on a common-anode 7-seg display.
// New values take effect only at frame boundaries. Each digit slot opens with an anode-off gap.
module seg7_scan_driver #(
    parameter int unsigned DIV       = 12500,
    parameter int unsigned BLANK_CYC = 100
) (
    input  logic        CLK100,
    input  logic        resetn,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  blank_i,
    input  logic [7:0]  dp_i,
    input  logic        lzb_en_i,
    output logic [7:0]  AN,
    output logic [6:0]  seg_o,
    output logic        DP,
    output logic        frame_o
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     disp_q, disp_d;
    logic            pending_q, pending_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic       slot_end;
    logic       commit;
    logic       in_blank;
    logic       digit_dark;
    logic [2:0] msd;
    logic [3:0] nibble;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // A zero-length blanking window must not produce a compare against zero.
    if (BLANK_CYC == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (cnt_q < CntW'(BLANK_CYC));
    end

    // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 always shows.
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (disp_q[4*k +: 4] != 4'h0) msd = 3'(k);
        end
    end

    always_comb begin
        slot_end   = (cnt_q == CntMax);
        commit     = slot_end && (idx_q == 3'd7);
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        idx_d      = slot_end ? idx_q + 3'd1 : idx_q;
        shadow_d   = load_i ? data_i : shadow_q;
        disp_d     = (commit && pending_q) ? shadow_q : disp_q;
        pending_d  = load_i | (pending_q & ~commit);
        frame_d    = commit;
        nibble     = disp_q[{idx_q, 2'b00} +: 4];
        digit_dark = blank_i[idx_q] | (lzb_en_i & (idx_q > msd));

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!in_blank) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = digit_dark ? 7'h7F : hex_decode(nibble);
            dp_d  = ~dp_i[idx_q];
        end
    end

    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'h0;
            disp_q    <= 32'h0;
            pending_q <= 1'b0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign AN      = an_q;
    assign seg_o   = seg_q;
    assign DP      = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: timeline model of frames and slots checked every cycle,
// plus directed literal expectations, on a BLANK_CYC=1 and a BLANK_CYC=0 instance.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int FR = 8 * D;

    logic        CLK100;
    logic        resetn;
    logic [31:0] data_i;
    logic        load_i;
    logic [7:0]  blank_i;
    logic [7:0]  dp_i;
    logic        lzb_en_i;
    logic [7:0]  an1, an0;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0, fr1, fr0;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.DIV(D), .BLANK_CYC(1)) dut (
        .CLK100(CLK100), .resetn(resetn), .data_i(data_i), .load_i(load_i),
        .blank_i(blank_i), .dp_i(dp_i), .lzb_en_i(lzb_en_i),
        .AN(an1), .seg_o(seg1), .DP(dp1), .frame_o(fr1)
    );

    seg7_scan_driver #(.DIV(D), .BLANK_CYC(0)) dut0 (
        .CLK100(CLK100), .resetn(resetn), .data_i(data_i), .load_i(load_i),
        .blank_i(blank_i), .dp_i(dp_i), .lzb_en_i(lzb_en_i),
        .AN(an0), .seg_o(seg0), .DP(dp0), .frame_o(fr0)
    );

    initial begin
        CLK100 = 1'b0;
        forever #5 CLK100 = ~CLK100;
    end

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Edge p (counted from reset release) drives outputs seen after it.
    int          p_q = 0;
    int          ld_p [$];
    logic [31:0] ld_v [$];
    logic        chk_en = 1'b0;
    logic        e_rst;
    logic [7:0]  e_an1, e_an0;
    logic [6:0]  e_seg1, e_seg0;
    logic        e_dp1, e_dp0, e_fr;

    // Value on display during the frame containing edge p: last load before that frame's commit edge.
    function automatic logic [31:0] frame_value(input int p);
        int          f = p / FR;
        logic [31:0] v = 32'h0;
        if (f == 0) return v;
        for (int i = 0; i < ld_p.size(); i++) begin
            if (ld_p[i] < f * FR - 1) v = ld_v[i];
        end
        return v;
    endfunction

    function automatic logic [7:0] m_an(input int p, input int bc);
        if ((p % D) < bc) return 8'hFF;
        return ~(8'h01 << ((p / D) % 8));
    endfunction

    function automatic logic [6:0] m_seg(input int p, input int bc, input logic [31:0] v,
                                         input logic [7:0] bl, input logic lz);
        int idx = (p / D) % 8;
        int msd = 0;
        if ((p % D) < bc) return 7'h7F;
        for (int k = 0; k < 8; k++) begin
            if (((v >> (4 * k)) & 32'hF) != 0) msd = k;
        end
        if (bl[idx] || (lz && idx > msd)) return 7'h7F;
        return seg_tab[int'((v >> (4 * idx)) & 32'hF)];
    endfunction

    function automatic logic m_dp(input int p, input int bc, input logic [7:0] dm);
        if ((p % D) < bc) return 1'b1;
        return ~dm[(p / D) % 8];
    endfunction

    always @(posedge CLK100) begin
        if (!resetn) begin
            p_q    <= 0;
            chk_en <= 1'b1;
            e_rst  <= 1'b1;
            e_an1  <= 8'hFF;
            e_seg1 <= 7'h7F;
            e_dp1  <= 1'b1;
            e_an0  <= 8'hFF;
            e_seg0 <= 7'h7F;
            e_dp0  <= 1'b1;
            e_fr   <= 1'b0;
            ld_p.delete();
            ld_v.delete();
        end else begin
            e_rst  <= 1'b0;
            e_an1  <= m_an(p_q, 1);
            e_seg1 <= m_seg(p_q, 1, frame_value(p_q), blank_i, lzb_en_i);
            e_dp1  <= m_dp(p_q, 1, dp_i);
            e_an0  <= m_an(p_q, 0);
            e_seg0 <= m_seg(p_q, 0, frame_value(p_q), blank_i, lzb_en_i);
            e_dp0  <= m_dp(p_q, 0, dp_i);
            e_fr   <= ((p_q % FR) == FR - 1);
            if (load_i) begin
                ld_p.push_back(p_q);
                ld_v.push_back(data_i);
            end
            p_q <= p_q + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK100) begin
        if (chk_en) begin
            check("an_b1", 32'(an1), 32'(e_an1));
            check("seg_b1", 32'(seg1), 32'(e_seg1));
            check("dp_b1", 32'(dp1), 32'(e_dp1));
            check("frame_b1", 32'(fr1), 32'(e_fr));
            check("an_b0", 32'(an0), 32'(e_an0));
            check("seg_b0", 32'(seg0), 32'(e_seg0));
            check("dp_b0", 32'(dp0), 32'(e_dp0));
            check("frame_b0", 32'(fr0), 32'(e_fr));
            if (!e_rst) check("an_b0_onehot", 32'($countones(~an0)), 32'd1);
        end
    end

    // Park at the falling edge right after edge n.
    task automatic goto(input int n);
        int guard = 0;
        while (p_q != n + 1 && guard < 5000) begin
            @(negedge CLK100);
            guard++;
        end
        if (p_q != n + 1) begin
            checks++;
            errors++;
            $display("FAIL goto: at edge %0d, expected edge %0d", p_q, n + 1);
        end
    endtask

    task automatic load(input logic [31:0] v);
        data_i = v;
        load_i = 1'b1;
        @(negedge CLK100);
        load_i = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        data_i   = 32'h0;
        load_i   = 1'b0;
        blank_i  = 8'h00;
        dp_i     = 8'h00;
        lzb_en_i = 1'b0;
        repeat (3) @(posedge CLK100);
        @(negedge CLK100);
        check("lit_rst_an", 32'(an1), 32'hFF);
        check("lit_rst_seg", 32'(seg1), 32'h7F);
        check("lit_rst_dp", 32'(dp1), 32'h1);
        check("lit_rst_frame", 32'(fr1), 32'h0);
        resetn = 1'b1;

        goto(0);  check("lit_first_blank", 32'(an1), 32'hFF);
                  check("lit_b0_first", 32'(an0), 32'hFE);
        goto(1);  check("lit_first_an", 32'(an1), 32'hFE);
                  check("lit_first_seg", 32'(seg1), 32'b0000001);
        goto(4);  load(32'h0123_4567);
        goto(29); check("lit_old_d7_an", 32'(an1), 32'h7F);
                  check("lit_old_d7_seg", 32'(seg1), 32'b0000001);
        goto(31); check("lit_frame_pulse", 32'(fr1), 32'h1);
        goto(33); check("lit_d0_an", 32'(an1), 32'hFE);
                  check("lit_d0_seg7", 32'(seg1), 32'b0001111);
        goto(37); check("lit_d1_an", 32'(an1), 32'hFD);
                  check("lit_d1_seg6", 32'(seg1), 32'b0100000);
        goto(61); check("lit_d7_seg0", 32'(seg1), 32'b0000001);

        goto(69); lzb_en_i = 1'b1;
                  load(32'h0000_00A5);
        goto(93); check("lit_lzb_old_d7", 32'(seg1), 32'h7F);
        goto(97); check("lit_a5_d0", 32'(seg1), 32'b0100100);
        goto(101); check("lit_a5_d1_an", 32'(an1), 32'hFD);
                   check("lit_a5_d1", 32'(seg1), 32'b0001000);
        goto(105); check("lit_lzb_d2_an", 32'(an1), 32'hFB);
                   check("lit_lzb_d2_seg", 32'(seg1), 32'h7F);
        goto(127); lzb_en_i = 1'b0;
        goto(137); check("lit_nolzb_d2", 32'(seg1), 32'b0000001);

        goto(149); load(32'h1111_1111);
        goto(158); load(32'h2222_2222);
        goto(189); check("lit_tear_f5", 32'(seg1), 32'b1001111);
        goto(193); check("lit_tear_f6_d0", 32'(seg1), 32'b0010010);

        goto(199); load(32'h8888_8888);
        goto(215); blank_i = 8'h0F;
                   dp_i    = 8'h80;
        goto(225); check("lit_blank_d0_an", 32'(an1), 32'hFE);
                   check("lit_blank_d0_seg", 32'(seg1), 32'h7F);
                   check("lit_blank_d0_dp", 32'(dp1), 32'h1);
        goto(241); check("lit_d4_an", 32'(an1), 32'hEF);
                   check("lit_d4_seg", 32'(seg1), 32'h00);
        goto(252); check("lit_gap_dp", 32'(dp1), 32'h1);
        goto(253); check("lit_d7_dp", 32'(dp1), 32'h0);

        goto(259); load(32'h9999_9999);
        resetn = 1'b0;
        repeat (2) @(negedge CLK100);
        check("lit_mid_rst_an", 32'(an1), 32'hFF);
        check("lit_mid_rst_seg", 32'(seg1), 32'h7F);
        blank_i = 8'h00;
        dp_i    = 8'h00;
        resetn  = 1'b1;
        goto(33); check("lit_pending_dropped", 32'(seg1), 32'b0000001);
        goto(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
